// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage program counter: sequential advance, prioritised redirects,
// redirect capture across stalls and memory back-pressure, and misaligned-target trap.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
    input  logic        Clk,
    input  logic        Reset_N,
    input  logic        Stall_In,
    input  logic        Br_Taken_In,
    input  logic [31:0] Br_Target_In,
    input  logic        Jmp_In,
    input  logic [31:0] Jmp_Target_In,
    input  logic        Jr_In,
    input  logic [31:0] Jr_Target_In,
    input  logic        Fetch_Ready_In,
    output logic        Fetch_Valid_Out,
    output logic [31:0] Pc_Out,
    output logic [31:0] Pc4_Out,
    output logic        Adel_Out
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_PEND = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_pend_tgt;
    logic [31:0] w_pend_nxt;
    logic        r_valid;
    logic        r_adel;
    logic        w_adel_nxt;

    logic        w_redir;
    logic [31:0] w_redir_tgt;
    logic        w_advance;
    logic [31:0] w_pc4;
    logic [31:0] w_apply_tgt;
    logic        w_apply_is_redir;

    function automatic logic [31:0] sel_target(
        input logic        jr,
        input logic        jmp,
        input logic [31:0] jr_tgt,
        input logic [31:0] jmp_tgt,
        input logic [31:0] br_tgt
    );
        if (jr)
            return jr_tgt;
        else if (jmp)
            return jmp_tgt;
        else
            return br_tgt;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return |low_bits;
    endfunction

    assign w_redir     = Jr_In | Jmp_In | Br_Taken_In;
    assign w_redir_tgt = sel_target(Jr_In, Jmp_In, Jr_Target_In, Jmp_Target_In, Br_Target_In);
    assign w_advance   = r_valid & Fetch_Ready_In & ~Stall_In;
    assign w_pc4       = r_pc + 32'd4;

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_pend_nxt       = r_pend_tgt;
        w_adel_nxt       = 1'b0;
        w_apply_tgt      = w_pc4;
        w_apply_is_redir = 1'b0;

        if (w_advance) begin
            w_state_nxt = S_RUN;
            // A live redirect always beats a captured one; the capture is stale by then.
            if (w_redir) begin
                w_apply_tgt      = w_redir_tgt;
                w_apply_is_redir = 1'b1;
            end else if (r_state == S_PEND) begin
                w_apply_tgt      = r_pend_tgt;
                w_apply_is_redir = 1'b1;
            end

            if (w_apply_is_redir && is_misaligned(w_apply_tgt[1:0])) begin
                w_pc_nxt   = EXC_PC;
                w_adel_nxt = 1'b1;
            end else begin
                w_pc_nxt = w_apply_tgt;
            end
        end else if (w_redir) begin
            w_state_nxt = S_PEND;
            w_pend_nxt  = w_redir_tgt;
        end else if (r_state == S_RUN && r_valid && !Fetch_Ready_In) begin
            w_state_nxt = S_WAIT;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            r_state    <= S_RUN;
            r_pc       <= RESET_PC;
            r_pend_tgt <= 32'd0;
            r_valid    <= 1'b0;
            r_adel     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_pend_tgt <= w_pend_nxt;
            r_valid    <= 1'b1;
            r_adel     <= w_adel_nxt;
        end
    end

    assign Fetch_Valid_Out = r_valid;
    assign Pc_Out          = r_pc;
    assign Pc4_Out         = w_pc4;
    assign Adel_Out        = r_adel;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural model.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC   = 32'h0000_4180;

    logic        Clk = 1'b0;
    logic        Reset_N;
    logic        Stall_In;
    logic        Br_Taken_In;
    logic [31:0] Br_Target_In;
    logic        Jmp_In;
    logic [31:0] Jmp_Target_In;
    logic        Jr_In;
    logic [31:0] Jr_Target_In;
    logic        Fetch_Ready_In;
    logic        Fetch_Valid_Out;
    logic [31:0] Pc_Out;
    logic [31:0] Pc4_Out;
    logic        Adel_Out;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model state: what the outputs must be after the most recent edge.
    logic [31:0] m_pc    = '0;
    logic        m_valid = 1'b0;
    logic        m_adel  = 1'b0;
    logic        m_pend  = 1'b0;
    logic [31:0] m_ptgt  = '0;

    pc_fetch_ctrl #(.RESET_PC(RESET_PC), .EXC_PC(EXC_PC)) dut (
        .Clk            (Clk),
        .Reset_N        (Reset_N),
        .Stall_In       (Stall_In),
        .Br_Taken_In    (Br_Taken_In),
        .Br_Target_In   (Br_Target_In),
        .Jmp_In         (Jmp_In),
        .Jmp_Target_In  (Jmp_Target_In),
        .Jr_In          (Jr_In),
        .Jr_Target_In   (Jr_Target_In),
        .Fetch_Ready_In (Fetch_Ready_In),
        .Fetch_Valid_Out(Fetch_Valid_Out),
        .Pc_Out         (Pc_Out),
        .Pc4_Out        (Pc4_Out),
        .Adel_Out       (Adel_Out)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin : model
        logic        adv;
        logic        any_redir;
        logic [31:0] tgt;
        logic [31:0] nxt;
        logic        use_tgt;
        if (!Reset_N) begin
            m_pc    = RESET_PC;
            m_valid = 1'b0;
            m_adel  = 1'b0;
            m_pend  = 1'b0;
            m_ptgt  = '0;
        end else begin
            adv       = m_valid && Fetch_Ready_In && !Stall_In;
            any_redir = Jr_In || Jmp_In || Br_Taken_In;
            tgt       = Jr_In ? Jr_Target_In : (Jmp_In ? Jmp_Target_In : Br_Target_In);
            m_adel    = 1'b0;
            if (adv) begin
                use_tgt = any_redir || m_pend;
                nxt = any_redir ? tgt : (m_pend ? m_ptgt : m_pc + 32'd4);
                if (use_tgt && (nxt % 4 != 0)) begin
                    m_pc   = EXC_PC;
                    m_adel = 1'b1;
                end else begin
                    m_pc = nxt;
                end
                m_pend = 1'b0;
            end else if (any_redir) begin
                m_pend = 1'b1;
                m_ptgt = tgt;
            end
            m_valid = 1'b1;
        end
    end

    always @(negedge Clk) begin : compare
        if (chk_en) begin
            n_cmp++;
            if (Pc_Out !== m_pc || Pc4_Out !== m_pc + 32'd4 ||
                Fetch_Valid_Out !== m_valid || Adel_Out !== m_adel) begin
                n_fail++;
                $display("FAIL model t=%0t pc=%h/%h pc4=%h/%h vld=%b/%b adel=%b/%b (got/exp)",
                         $time, Pc_Out, m_pc, Pc4_Out, m_pc + 32'd4,
                         Fetch_Valid_Out, m_valid, Adel_Out, m_adel);
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        Stall_In       = 1'b0;
        Br_Taken_In    = 1'b0;
        Jmp_In         = 1'b0;
        Jr_In          = 1'b0;
        Br_Target_In   = '0;
        Jmp_Target_In  = '0;
        Jr_Target_In   = '0;
        Fetch_Ready_In = 1'b1;
    endtask

    // Called at a negedge; leaves the bench at the negedge after reset is released.
    task automatic do_reset();
        Reset_N = 1'b0;
        repeat (2) @(negedge Clk);
        lit("rst_valid", {31'd0, Fetch_Valid_Out}, 32'd0);
        lit("rst_pc", Pc_Out, RESET_PC);
        lit("rst_adel", {31'd0, Adel_Out}, 32'd0);
        Reset_N = 1'b1;
        @(negedge Clk);
        lit("rel_valid", {31'd0, Fetch_Valid_Out}, 32'd1);
        lit("rel_pc", Pc_Out, RESET_PC);
    endtask

    task automatic jump_to(input logic [31:0] t);
        Jmp_In = 1'b1;
        Jmp_Target_In = t;
        @(negedge Clk);
        Jmp_In = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        Reset_N = 1'b0;
        idle_inputs();
        Stall_In = 1'b1;
        Jr_In = 1'b1;
        Jr_Target_In = 32'h0000_5000;
        @(negedge Clk);
        chk_en = 1'b1;
        idle_inputs();
        do_reset();

        // Free-running sequential fetch
        @(negedge Clk); lit("seq_3004", Pc_Out, 32'h0000_3004);
        @(negedge Clk); lit("seq_3008", Pc_Out, 32'h0000_3008);
        @(negedge Clk); lit("seq_300C", Pc_Out, 32'h0000_300C);
        lit("seq_pc4", Pc4_Out, 32'h0000_3010);

        // Branch captured during a two-cycle stall
        jump_to(32'h0000_3008);
        lit("stall_pre", Pc_Out, 32'h0000_3008);
        Stall_In = 1'b1; Br_Taken_In = 1'b1; Br_Target_In = 32'h0000_3040;
        @(negedge Clk); lit("stall_c1", Pc_Out, 32'h0000_3008);
        Br_Taken_In = 1'b0;
        @(negedge Clk); lit("stall_c2", Pc_Out, 32'h0000_3008);
        Stall_In = 1'b0;
        @(negedge Clk); lit("stall_apply", Pc_Out, 32'h0000_3040);

        // Target priority
        Jr_In = 1'b1; Jmp_In = 1'b1; Br_Taken_In = 1'b1;
        Jr_Target_In = 32'h0000_3100; Jmp_Target_In = 32'h0000_3200; Br_Target_In = 32'h0000_3300;
        @(negedge Clk); lit("prio_jr", Pc_Out, 32'h0000_3100);
        idle_inputs();

        // Misaligned register target
        Jr_In = 1'b1; Jr_Target_In = 32'h0000_3102;
        @(negedge Clk);
        lit("adel_pc", Pc_Out, EXC_PC);
        lit("adel_hi", {31'd0, Adel_Out}, 32'd1);
        idle_inputs();
        @(negedge Clk);
        lit("adel_lo", {31'd0, Adel_Out}, 32'd0);
        lit("adel_next", Pc_Out, 32'h0000_4184);

        // Memory back-pressure and wrap-around
        jump_to(32'h0000_3010);
        Fetch_Ready_In = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk); lit("wait_hold", Pc_Out, 32'h0000_3010);
        end
        Fetch_Ready_In = 1'b1;
        @(negedge Clk); lit("wait_release", Pc_Out, 32'h0000_3014);
        jump_to(32'hFFFF_FFFC);
        lit("wrap_pc4", Pc4_Out, 32'h0000_0000);
        @(negedge Clk); lit("wrap_pc", Pc_Out, 32'h0000_0000);

        // Reset drops a pending redirect
        Fetch_Ready_In = 1'b0;
        Jmp_In = 1'b1; Jmp_Target_In = 32'h0000_3500;
        @(negedge Clk);
        idle_inputs();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (Pc_Out === 32'h0000_3500) begin
                n_fail++;
                $display("FAIL stale_pend got=%h exp=not 00003500", Pc_Out);
            end
            @(negedge Clk);
        end
        lit("post_rst_seq", Pc_Out, 32'h0000_3018);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            Reset_N        = ($urandom_range(0, 199) != 0);
            Stall_In       = ($urandom_range(0, 3) == 0);
            Fetch_Ready_In = ($urandom_range(0, 9) < 7);
            Jr_In          = ($urandom_range(0, 9) == 0);
            Jmp_In         = ($urandom_range(0, 9) == 0);
            Br_Taken_In    = ($urandom_range(0, 7) == 0);
            Jr_Target_In   = $urandom & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            Jmp_Target_In  = $urandom & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            Br_Target_In   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC :
                             ($urandom & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC));
            @(negedge Clk);
        end

        Reset_N = 1'b1;
        idle_inputs();
        @(negedge Clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
